// File: rtl/alu_multiword_seq.sv
// Multi-word sequencer around a single-word combinational ALU.
// Issues one word per cycle, chains carry between words and folds the zero flag across words.
module alu_multiword_seq #(
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_WORDS   = 4,
  parameter int OPER_WIDTH  = 4,
  parameter int FLAGS_WIDTH = 4,
  parameter int WC_WIDTH    = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [OPER_WIDTH-1:0]           req_oper,
  input  logic [DATA_WIDTH*MAX_WORDS-1:0] req_a,
  input  logic [DATA_WIDTH*MAX_WORDS-1:0] req_b,
  input  logic [WC_WIDTH-1:0]             req_words_m1,
  input  logic                            req_c,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [DATA_WIDTH*MAX_WORDS-1:0] rsp_result,
  output logic                            rsp_c,
  output logic                            rsp_z,
  output logic                            rsp_err,
  output logic [OPER_WIDTH-1:0]           alu_oper,
  output logic [DATA_WIDTH-1:0]           alu_a,
  output logic [DATA_WIDTH-1:0]           alu_b,
  output logic [FLAGS_WIDTH-1:0]          alu_flags_in,
  input  logic [DATA_WIDTH-1:0]           alu_out,
  input  logic [FLAGS_WIDTH-1:0]          alu_flags_out
);

  localparam logic [OPER_WIDTH-1:0] OP_ADD = OPER_WIDTH'(0);
  localparam logic [OPER_WIDTH-1:0] OP_ADC = OPER_WIDTH'(1);
  localparam logic [OPER_WIDTH-1:0] OP_SUB = OPER_WIDTH'(2);
  localparam logic [OPER_WIDTH-1:0] OP_SBC = OPER_WIDTH'(3);
  localparam logic [OPER_WIDTH-1:0] OP_AND = OPER_WIDTH'(4);
  localparam logic [OPER_WIDTH-1:0] OP_ORR = OPER_WIDTH'(5);
  localparam logic [OPER_WIDTH-1:0] OP_XOR = OPER_WIDTH'(6);
  localparam logic [OPER_WIDTH-1:0] OP_LSL = OPER_WIDTH'(7);
  localparam logic [OPER_WIDTH-1:0] OP_LSR = OPER_WIDTH'(8);
  localparam logic [OPER_WIDTH-1:0] OP_CMP = OPER_WIDTH'(9);

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]                            state_reg;
  logic [OPER_WIDTH-1:0]                 oper_reg;
  logic [DATA_WIDTH*MAX_WORDS-1:0]       a_reg;
  logic [DATA_WIDTH*MAX_WORDS-1:0]       b_reg;
  logic [WC_WIDTH-1:0]                   n_m1_reg;
  logic [WC_WIDTH-1:0]                   cnt_reg;
  logic                                  carry_reg;
  logic                                  z_reg;
  logic                                  err_reg;
  logic [DATA_WIDTH-1:0]                 result_words_reg [MAX_WORDS];

  logic [DATA_WIDTH-1:0]                 a_words [MAX_WORDS];
  logic [DATA_WIDTH-1:0]                 b_words [MAX_WORDS];
  logic [WC_WIDTH-1:0]                   words_m1_clamped;
  logic [WC_WIDTH-1:0]                   word_idx;
  logic [OPER_WIDTH-1:0]                 issue_oper;
  logic [DATA_WIDTH-1:0]                 stored_word;
  logic                                  carry_next;
  logic                                  word_zero;
  logic                                  issuing;
  logic                                  flags_unused;

  assign flags_unused = ^alu_flags_out;

  function automatic logic is_supported(input logic [OPER_WIDTH-1:0] op);
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP,
      OP_AND, OP_ORR, OP_XOR, OP_LSR: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  generate
    for (genvar gi = 0; gi < MAX_WORDS; gi++) begin : g_words
      assign a_words[gi] = a_reg[gi*DATA_WIDTH +: DATA_WIDTH];
      assign b_words[gi] = b_reg[gi*DATA_WIDTH +: DATA_WIDTH];
      assign rsp_result[gi*DATA_WIDTH +: DATA_WIDTH] = result_words_reg[gi];
    end
  endgenerate

  always_comb begin
    words_m1_clamped = req_words_m1;
    if (int'(req_words_m1) > MAX_WORDS - 1) words_m1_clamped = WC_WIDTH'(MAX_WORDS - 1);
  end

  // Shifts walk from the most significant word down; everything else goes LSW first.
  assign word_idx = (oper_reg == OP_LSR) ? (n_m1_reg - cnt_reg) : cnt_reg;
  assign issuing  = (state_reg == ST_RUN) && !err_reg;

  always_comb begin
    issue_oper = oper_reg;
    case (oper_reg)
      OP_ADD:         issue_oper = (cnt_reg == '0) ? OP_ADD : OP_ADC;
      OP_SUB, OP_CMP: issue_oper = (cnt_reg == '0) ? OP_SUB : OP_SBC;
      default:        issue_oper = oper_reg;
    endcase
  end

  always_comb begin
    alu_oper     = OP_ADD;
    alu_a        = '0;
    alu_b        = '0;
    alu_flags_in = '0;
    if (issuing) begin
      alu_oper             = issue_oper;
      alu_a                = a_words[word_idx];
      alu_b                = b_words[word_idx];
      alu_flags_in[FLAG_C] = carry_reg;
    end
  end

  always_comb begin
    stored_word = alu_out;
    carry_next  = alu_flags_out[FLAG_C];
    word_zero   = (alu_out == '0);
    case (oper_reg)
      OP_LSR: begin
        stored_word[DATA_WIDTH-1] = carry_reg;
        word_zero = (stored_word == '0);
      end
      OP_AND, OP_ORR, OP_XOR: carry_next = carry_reg;
      OP_CMP: word_zero = alu_flags_out[FLAG_Z];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      oper_reg  <= OP_ADD;
      a_reg     <= '0;
      b_reg     <= '0;
      n_m1_reg  <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      z_reg     <= 1'b0;
      err_reg   <= 1'b0;
      for (int i = 0; i < MAX_WORDS; i++) result_words_reg[i] <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            oper_reg  <= req_oper;
            a_reg     <= req_a;
            b_reg     <= req_b;
            n_m1_reg  <= words_m1_clamped;
            cnt_reg   <= '0;
            carry_reg <= req_c;
            z_reg     <= is_supported(req_oper);
            err_reg   <= !is_supported(req_oper);
            // Words beyond n read back as zero; compare leaves the old result visible.
            if (req_oper != OP_CMP || !is_supported(req_oper)) begin
              for (int i = 0; i < MAX_WORDS; i++) result_words_reg[i] <= '0;
            end
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (err_reg) begin
            state_reg <= ST_DONE;
          end else begin
            if (oper_reg != OP_CMP) result_words_reg[word_idx] <= stored_word;
            carry_reg <= carry_next;
            z_reg     <= z_reg & word_zero;
            if (cnt_reg == n_m1_reg) state_reg <= ST_DONE;
            else                     cnt_reg   <= cnt_reg + WC_WIDTH'(1);
          end
        end
        ST_DONE: begin
          if (rsp_ready) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state_reg == ST_IDLE);
  assign rsp_valid = (state_reg == ST_DONE);
  assign rsp_c     = carry_reg;
  assign rsp_z     = z_reg;
  assign rsp_err   = err_reg;

endmodule

// File: tb/tb_alu_multiword_seq.sv
// Directed bench for alu_multiword_seq with a behavioural single-word ALU attached.
// Each transaction prints one line; miscompares are reported through immediate assertions.
module tb_alu_multiword_seq;
  localparam int DW = 8;
  localparam int MW = 4;
  localparam int OW = 4;
  localparam int FW = 4;
  localparam int WW = 2;

  localparam logic [OW-1:0] OP_ADD = 4'd0;
  localparam logic [OW-1:0] OP_ADC = 4'd1;
  localparam logic [OW-1:0] OP_SUB = 4'd2;
  localparam logic [OW-1:0] OP_SBC = 4'd3;
  localparam logic [OW-1:0] OP_AND = 4'd4;
  localparam logic [OW-1:0] OP_ORR = 4'd5;
  localparam logic [OW-1:0] OP_XOR = 4'd6;
  localparam logic [OW-1:0] OP_LSL = 4'd7;
  localparam logic [OW-1:0] OP_LSR = 4'd8;
  localparam logic [OW-1:0] OP_CMP = 4'd9;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [OW-1:0]     req_oper = '0;
  logic [DW*MW-1:0]  req_a = '0;
  logic [DW*MW-1:0]  req_b = '0;
  logic [WW-1:0]     req_words_m1 = '0;
  logic              req_c = 1'b0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DW*MW-1:0]  rsp_result;
  logic              rsp_c;
  logic              rsp_z;
  logic              rsp_err;
  logic [OW-1:0]     alu_oper;
  logic [DW-1:0]     alu_a;
  logic [DW-1:0]     alu_b;
  logic [FW-1:0]     alu_flags_in;
  logic [DW-1:0]     alu_out;
  logic [FW-1:0]     alu_flags_out;

  alu_multiword_seq #(
    .DATA_WIDTH(DW), .MAX_WORDS(MW), .OPER_WIDTH(OW), .FLAGS_WIDTH(FW), .WC_WIDTH(WW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_oper(req_oper),
    .req_a(req_a), .req_b(req_b), .req_words_m1(req_words_m1), .req_c(req_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_c(rsp_c), .rsp_z(rsp_z), .rsp_err(rsp_err),
    .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b), .alu_flags_in(alu_flags_in),
    .alu_out(alu_out), .alu_flags_out(alu_flags_out)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: C is bit 0, Z is bit 1; subtract C=1 means no borrow.
  logic [DW:0] alu_sum;
  logic        alu_cout;
  always_comb begin
    alu_sum  = '0;
    alu_out  = '0;
    alu_cout = alu_flags_in[0];
    case (alu_oper)
      OP_ADD: begin alu_sum = {1'b0, alu_a} + {1'b0, alu_b}; alu_out = alu_sum[DW-1:0]; alu_cout = alu_sum[DW]; end
      OP_ADC: begin alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {{DW{1'b0}}, alu_flags_in[0]}; alu_out = alu_sum[DW-1:0]; alu_cout = alu_sum[DW]; end
      OP_SUB: begin alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1; alu_out = alu_sum[DW-1:0]; alu_cout = alu_sum[DW]; end
      OP_SBC: begin alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {{DW{1'b0}}, alu_flags_in[0]}; alu_out = alu_sum[DW-1:0]; alu_cout = alu_sum[DW]; end
      OP_AND: alu_out = alu_a & alu_b;
      OP_ORR: alu_out = alu_a | alu_b;
      OP_XOR: alu_out = alu_a ^ alu_b;
      OP_LSR: begin alu_out = alu_a >> 1; alu_cout = alu_a[0]; end
      OP_LSL: begin alu_out = alu_a << 1; alu_cout = alu_a[DW-1]; end
      default: alu_out = '0;
    endcase
    alu_flags_out = {2'b00, (alu_out == '0), alu_cout};
  end

  int vectors = 0;
  int miscompares = 0;
  int lat;
  logic [OW-1:0] ops [8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [OW-1:0] op, input logic [DW*MW-1:0] a, input logic [DW*MW-1:0] b,
                      input logic [WW-1:0] wm1, input logic c);
    int t = 0;
    while (!req_ready && t < 50) begin @(posedge clk); #1; t++; end
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_oper = op; req_a = a; req_b = b; req_words_m1 = wm1; req_c = c;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    lat = 0;
    for (int i = 0; i < 8; i++) ops[i] = 'x;
    for (int k = 1; k <= 20; k++) begin
      if (k <= 8) ops[k-1] = alu_oper;
      @(posedge clk); #1;
      if (rsp_valid) begin lat = k; break; end
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic txn(input string tag, input logic [OW-1:0] op, input logic [DW*MW-1:0] a,
                     input logic [DW*MW-1:0] b, input logic [WW-1:0] wm1, input logic c,
                     input int exp_lat, input logic [DW*MW-1:0] exp_res, input logic exp_c,
                     input logic exp_z, input logic exp_err);
    send(op, a, b, wm1, c);
    wait_rsp();
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".result"}, rsp_result, exp_res);
    check({tag, ".c"}, rsp_c, exp_c);
    check({tag, ".z"}, rsp_z, exp_z);
    check({tag, ".err"}, rsp_err, exp_err);
    $display("txn %s: lat=%0d result=%08h c=%b z=%b err=%b", tag, lat, rsp_result, rsp_c, rsp_z, rsp_err);
    consume();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset.req_ready", req_ready, 1);
    check("reset.rsp_valid", rsp_valid, 0);
    check("reset.result", rsp_result, 0);
    check("reset.c", rsp_c, 0);
    check("reset.z", rsp_z, 0);
    check("reset.err", rsp_err, 0);
    check("reset.alu_oper", alu_oper, OP_ADD);
    check("reset.alu_a", alu_a, 0);

    txn("add_n2", OP_ADD, 32'h0000_00FF, 32'h0000_0001, 2'd1, 1'b0, 2, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    check("add_n2.op0", ops[0], OP_ADD);
    check("add_n2.op1", ops[1], OP_ADC);

    txn("sub_n4", OP_SUB, 32'h1234_5678, 32'h1234_5678, 2'd3, 1'b0, 4, 32'h0, 1'b1, 1'b1, 1'b0);
    check("sub_n4.op3", ops[3], OP_SBC);
    txn("sbc_n1", OP_SBC, 32'h0, 32'h0, 2'd0, 1'b0, 1, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);

    txn("add_prior", OP_ADD, 32'h0000_ABCC, 32'h0000_0001, 2'd1, 1'b0, 2, 32'h0000_ABCD, 1'b0, 1'b0, 1'b0);
    txn("cmp_n2", OP_CMP, 32'h0000_0100, 32'h0000_0200, 2'd1, 1'b1, 2, 32'h0000_ABCD, 1'b0, 1'b0, 1'b0);
    check("cmp_n2.op0", ops[0], OP_SUB);
    check("cmp_n2.op1", ops[1], OP_SBC);

    txn("lsr_n3", OP_LSR, 32'h0000_0101, 32'h0, 2'd2, 1'b0, 3, 32'h0000_0080, 1'b1, 1'b0, 1'b0);
    check("lsr_n3.op0", ops[0], OP_LSR);
    txn("lsr_n1", OP_LSR, 32'h0000_0001, 32'h0, 2'd0, 1'b1, 1, 32'h0000_0080, 1'b1, 1'b0, 1'b0);

    txn("and_n1", OP_AND, 32'h0000_00F0, 32'h0000_000F, 2'd0, 1'b1, 1, 32'h0, 1'b1, 1'b1, 1'b0);
    txn("xor_n2", OP_XOR, 32'h0000_F00F, 32'h0000_0FF0, 2'd1, 1'b0, 2, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
    txn("lsl_err", OP_LSL, 32'h0000_0055, 32'h0, 2'd0, 1'b1, 1, 32'h0, 1'b1, 1'b0, 1'b1);
    check("lsl_err.alu_idle", ops[0], OP_ADD);

    // Response held back: outputs must not move, and a new request must not be taken.
    send(OP_ADD, 32'h0000_0005, 32'h0000_0003, 2'd0, 1'b0);
    wait_rsp();
    check("hold.latency", lat, 1);
    check("hold.err_cleared", rsp_err, 0);
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold.rsp_valid", rsp_valid, 1);
      check("hold.req_ready", req_ready, 0);
      check("hold.result", rsp_result, 32'h0000_0008);
      check("hold.c", rsp_c, 0);
    end
    req_valid = 1'b0;
    $display("txn hold: result=%08h c=%b z=%b err=%b", rsp_result, rsp_c, rsp_z, rsp_err);
    consume();

    // Reset during the second RUN cycle of a four-word add.
    send(OP_ADD, 32'h1111_1111, 32'h2222_2222, 2'd3, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst.req_ready", req_ready, 1);
    check("midrst.rsp_valid", rsp_valid, 0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seen = seen | rsp_valid;
    end
    check("midrst.no_rsp", seen, 0);
    $display("txn midrst: req_ready=%b rsp_valid_seen=%b", req_ready, seen);
    txn("after_rst", OP_ADD, 32'h0000_0001, 32'h0000_0001, 2'd0, 1'b0, 1, 32'h0000_0002, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
